// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer: PC type, FSM states, reset PC and step.
// Combinational helpers only; no latency, no backpressure.
package fetch_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] pc_t;

  localparam pc_t RESET_PC = pc_t'(0);
  localparam pc_t PC_STEP  = pc_t'(4);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } state_e;

  // Instructions are word aligned, so redirect targets drop their low two bits.
  function automatic pc_t align_pc(input pc_t addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control, imem request/response and decode handshake bundle for the fetch sequencer.
// Master = sequencer side, slave = pipeline/memory side.
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic        en;
  logic        redirect_valid;
  pc_t         redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  pc_t         imem_req_addr;
  logic        imem_rsp_valid;
  pc_t         imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  pc_t         if_pc;
  pc_t         if_instr;
  logic [31:0] fetch_count;

  modport master (
    input  en, redirect_valid, redirect_target,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_count
  );

  modport slave (
    output en, redirect_valid, redirect_target,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_count
  );

endinterface

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter: aligned load from a redirect target, wrap-around step, otherwise hold.
// Load wins over increment; new value visible the cycle after the edge.
module pc_reg
  import fetch_pkg::*;
#(
  parameter pc_t RST_VAL = RESET_PC,
  parameter pc_t STEP    = PC_STEP
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  pc_t  i_target,
  input  logic i_inc,
  output pc_t  o_pc
);

  pc_t r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RST_VAL;
    end else if (i_load) begin
      r_pc <= align_pc(i_target);
    end else if (i_inc) begin
      r_pc <= r_pc + STEP;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: one outstanding imem request, if_valid 3 cycles after en with ready memory.
// Stalls in REQ while imem_req_ready=0 and in HOLD while if_ready=0; redirects flush via kill.
module fetch_sequencer
  import fetch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  fetch_sequencer_if.master bus
);

  state_e      r_state;
  state_e      w_next;
  logic        r_kill;
  pc_t         r_if_pc;
  pc_t         r_if_instr;
  logic [31:0] r_fetch_count;

  pc_t  w_pc;
  logic w_req_vld;
  logic w_if_vld;
  logic w_pc_load;
  logic w_pc_inc;
  logic w_capture;
  logic w_kill_set;
  logic w_kill_clr;

  pc_reg u_pc_reg (
    .clk      (clk),
    .rst      (reset),
    .i_load   (w_pc_load),
    .i_target (bus.redirect_target),
    .i_inc    (w_pc_inc),
    .o_pc     (w_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.en) w_next = ST_REQ;
      end
      ST_REQ: begin
        // A redirect keeps the request up (at the new pc) even if en drops.
        if (bus.imem_req_ready)                      w_next = ST_WAIT;
        else if (!bus.redirect_valid && !bus.en)     w_next = ST_IDLE;
      end
      ST_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (!r_kill && !bus.redirect_valid) w_next = ST_HOLD;
          else if (r_kill)                    w_next = bus.en ? ST_REQ : ST_IDLE;
          else                                w_next = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (bus.redirect_valid || bus.if_ready) w_next = bus.en ? ST_REQ : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_req_vld  = (r_state == ST_REQ);
    w_if_vld   = (r_state == ST_HOLD);
    w_pc_load  = bus.redirect_valid;
    w_pc_inc   = (r_state == ST_HOLD) && !bus.redirect_valid && bus.if_ready;
    w_capture  = (r_state == ST_WAIT) && bus.imem_rsp_valid && !r_kill && !bus.redirect_valid;
    w_kill_set = ((r_state == ST_REQ)  && bus.redirect_valid && bus.imem_req_ready) ||
                 ((r_state == ST_WAIT) && bus.redirect_valid && !bus.imem_rsp_valid);
    w_kill_clr = (r_state == ST_WAIT) && bus.imem_rsp_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kill        <= 1'b0;
      r_if_pc       <= '0;
      r_if_instr    <= '0;
      r_fetch_count <= '0;
    end else begin
      if (w_kill_clr)      r_kill <= 1'b0;
      else if (w_kill_set) r_kill <= 1'b1;
      if (w_capture) begin
        r_if_pc    <= w_pc;
        r_if_instr <= bus.imem_rsp_data;
      end
      if (w_pc_inc) r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign bus.imem_req_valid = w_req_vld;
  assign bus.imem_req_addr  = w_pc;
  assign bus.if_valid       = w_if_vld;
  assign bus.if_pc          = r_if_pc;
  assign bus.if_instr       = r_if_instr;
  assign bus.fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: vector table, directed corner sequences, random traffic vs. a flag-based model.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    logic        en, rdy, rsp;
    logic [31:0] dat;
    logic        ird;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc, ins, cnt;
  } vec_t;

  vec_t tv[12];

  // Reference model state: flags describing where the one fetch currently is.
  logic        m_req, m_busy, m_stale, m_present;
  logic [31:0] m_pc, m_ppc, m_pins, m_cnt;
  int          rsp_cnt;
  logic [31:0] rsp_addr;

  function automatic vec_t mk(logic en, logic rdy, logic rsp, logic [31:0] dat, logic ird,
                              logic rv, logic [31:0] addr, logic iv, logic [31:0] ipc,
                              logic [31:0] ins, logic [31:0] cnt);
    vec_t v;
    v.en = en; v.rdy = rdy; v.rsp = rsp; v.dat = dat; v.ird = ird;
    v.rv = rv; v.addr = addr; v.iv = iv; v.ipc = ipc; v.ins = ins; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return (a ^ 32'h1357_9BDF) + 32'd7;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input logic rv, input logic [31:0] addr, input logic iv,
                         input logic [31:0] ipc, input logic [31:0] ins, input logic [31:0] cnt);
    chk({nm, ".req_valid"}, 32'(bus.imem_req_valid), 32'(rv));
    chk({nm, ".req_addr"},  bus.imem_req_addr, addr);
    chk({nm, ".if_valid"},  32'(bus.if_valid), 32'(iv));
    chk({nm, ".if_pc"},     bus.if_pc, ipc);
    chk({nm, ".if_instr"},  bus.if_instr, ins);
    chk({nm, ".count"},     bus.fetch_count, cnt);
  endtask

  task automatic drive(input logic en, input logic rdy, input logic rsp, input logic [31:0] dat,
                       input logic ird, input logic rd, input logic [31:0] tgt);
    bus.en = en; bus.imem_req_ready = rdy; bus.imem_rsp_valid = rsp; bus.imem_rsp_data = dat;
    bus.if_ready = ird; bus.redirect_valid = rd; bus.redirect_target = tgt;
  endtask

  task automatic cyc(input logic en, input logic rdy, input logic rsp, input logic [31:0] dat,
                     input logic ird, input logic rd, input logic [31:0] tgt);
    drive(en, rdy, rsp, dat, ird, rd, tgt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic rd, input logic [31:0] tgt, input logic rdy,
                            input logic rsp_v, input logic [31:0] rsp_d, input logic ird);
    logic [31:0] t;
    t = tgt & 32'hFFFF_FFFC;
    if (m_req) begin
      if (rd) m_pc = t;
      if (rdy) begin
        m_req = 1'b0; m_busy = 1'b1; m_stale = rd;
      end else if (!rd && !en) begin
        m_req = 1'b0;
      end
    end else if (m_busy) begin
      if (rsp_v) begin
        m_busy = 1'b0;
        if (m_stale) begin
          m_stale = 1'b0; m_req = en;
        end else if (rd) begin
          m_req = 1'b1;
        end else begin
          m_present = 1'b1; m_ppc = m_pc; m_pins = rsp_d;
        end
      end else if (rd) begin
        m_stale = 1'b1;
      end
      if (rd) m_pc = t;
    end else if (m_present) begin
      if (rd) begin
        m_pc = t; m_present = 1'b0; m_req = en;
      end else if (ird) begin
        m_cnt = m_cnt + 32'd1; m_pc = m_pc + 32'd4; m_present = 1'b0; m_req = en;
      end
    end else begin
      if (rd) m_pc = t;
      if (en) m_req = 1'b1;
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Memory always ready, 1-cycle response of 0x13, decode always ready.
    tv[0]  = mk(1, 1, 0, 32'h0,  1, 0, 32'h0, 0, 32'h0, 32'h0,  32'd0);
    tv[1]  = mk(1, 1, 0, 32'h0,  1, 1, 32'h0, 0, 32'h0, 32'h0,  32'd0);
    tv[2]  = mk(1, 1, 1, 32'h13, 1, 0, 32'h0, 0, 32'h0, 32'h0,  32'd0);
    tv[3]  = mk(1, 1, 0, 32'h0,  1, 0, 32'h0, 1, 32'h0, 32'h13, 32'd0);
    tv[4]  = mk(1, 1, 0, 32'h0,  1, 1, 32'h4, 0, 32'h0, 32'h13, 32'd1);
    tv[5]  = mk(1, 1, 1, 32'h13, 1, 0, 32'h4, 0, 32'h0, 32'h13, 32'd1);
    tv[6]  = mk(1, 1, 0, 32'h0,  1, 0, 32'h4, 1, 32'h4, 32'h13, 32'd1);
    tv[7]  = mk(1, 1, 0, 32'h0,  1, 1, 32'h8, 0, 32'h4, 32'h13, 32'd2);
    tv[8]  = mk(1, 1, 1, 32'h13, 1, 0, 32'h8, 0, 32'h4, 32'h13, 32'd2);
    tv[9]  = mk(1, 1, 0, 32'h0,  1, 0, 32'h8, 1, 32'h8, 32'h13, 32'd2);
    tv[10] = mk(0, 0, 0, 32'h0,  0, 1, 32'hC, 0, 32'h8, 32'h13, 32'd3);
    tv[11] = mk(0, 0, 0, 32'h0,  0, 0, 32'hC, 0, 32'h8, 32'h13, 32'd3);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk_out($sformatf("vec%0d", i), tv[i].rv, tv[i].addr, tv[i].iv, tv[i].ipc, tv[i].ins, tv[i].cnt);
      cyc(tv[i].en, tv[i].rdy, tv[i].rsp, tv[i].dat, tv[i].ird, 1'b0, 32'h0);
    end

    // Request stall, then redirect during the stall.
    do_reset();
    cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("stall.valid", 32'(bus.imem_req_valid), 32'd1);
      chk("stall.addr", bus.imem_req_addr, 32'h0);
      cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);
    end
    cyc(1, 0, 0, 32'h0, 0, 1, 32'h100);
    chk("stall_redir.addr", bus.imem_req_addr, 32'h100);
    chk("stall_redir.valid", 32'(bus.imem_req_valid), 32'd1);

    // Redirect while waiting for the response to 0x8.
    cyc(1, 0, 0, 32'h0, 0, 1, 32'h8);
    chk("wait.addr8", bus.imem_req_addr, 32'h8);
    cyc(1, 1, 0, 32'h0, 0, 0, 32'h0);
    chk("wait.req_low", 32'(bus.imem_req_valid), 32'd0);
    cyc(1, 0, 0, 32'h0, 0, 1, 32'h200);
    chk("wait_redir.if_valid", 32'(bus.if_valid), 32'd0);
    cyc(1, 0, 1, 32'hDEAD, 0, 0, 32'h0);
    chk_out("wait_discard", 1, 32'h200, 0, 32'h0, 32'h0, 32'd0);

    // Decode stall in HOLD, then redirect together with if_ready.
    cyc(1, 1, 0, 32'h0, 0, 0, 32'h0);
    cyc(1, 0, 1, 32'h55, 0, 0, 32'h0);
    chk_out("hold0", 0, 32'h200, 1, 32'h200, 32'h55, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);
      chk_out("hold_stall", 0, 32'h200, 1, 32'h200, 32'h55, 32'd0);
    end
    cyc(1, 0, 0, 32'h0, 1, 1, 32'h300);
    chk_out("hold_flush", 1, 32'h300, 0, 32'h200, 32'h55, 32'd0);

    // Misaligned redirect near the top of the address space, then wrap.
    cyc(1, 0, 0, 32'h0, 0, 1, 32'hFFFF_FFFF);
    chk("align.addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    cyc(1, 1, 0, 32'h0, 0, 0, 32'h0);
    cyc(1, 0, 1, 32'h77, 0, 0, 32'h0);
    chk("wrap.if_pc", bus.if_pc, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 32'h0, 1, 0, 32'h0);
    chk_out("wrap", 1, 32'h0, 0, 32'hFFFF_FFFC, 32'h77, 32'd1);

    // Reset while waiting, then a stale response must be ignored.
    cyc(1, 1, 0, 32'h0, 0, 0, 32'h0);
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    reset = 1'b1;
    #1;
    chk_out("rst_async", 0, 32'h0, 0, 32'h0, 32'h0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 0, 1, 32'hBAD, 0, 0, 32'h0);
    chk_out("stale_rsp", 0, 32'h0, 0, 32'h0, 32'h0, 32'd0);
    cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);
    chk_out("restart", 1, 32'h0, 0, 32'h0, 32'h0, 32'd0);
    cyc(1, 1, 0, 32'h0, 0, 0, 32'h0);
    cyc(1, 0, 1, 32'h99, 0, 0, 32'h0);
    chk_out("restart_hold", 0, 32'h0, 1, 32'h0, 32'h99, 32'd0);

    // Random traffic against the model; memory answers 1..3 cycles after acceptance.
    do_reset();
    m_req = 0; m_busy = 0; m_stale = 0; m_present = 0;
    m_pc = 32'h0; m_ppc = 32'h0; m_pins = 32'h0; m_cnt = 32'h0;
    rsp_cnt = 0; rsp_addr = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      logic        r_en, r_rd, r_rdy, r_rv, r_ird;
      logic [31:0] r_tgt, r_dat;
      chk_out("rnd", m_req, m_pc, m_present, m_ppc, m_pins, m_cnt);
      r_en  = ($urandom % 8) != 0;
      r_rd  = ($urandom % 10) == 0;
      r_tgt = $urandom;
      r_rdy = ($urandom % 2) != 0;
      r_ird = ($urandom % 3) != 0;
      r_rv  = (rsp_cnt == 1);
      r_dat = r_rv ? instr_of(rsp_addr) : $urandom;
      drive(r_en, r_rdy, r_rv, r_dat, r_ird, r_rd, r_tgt);
      if (rsp_cnt != 0) rsp_cnt--;
      if (m_req && r_rdy) begin
        rsp_cnt  = int'($urandom_range(1, 3));
        rsp_addr = m_pc;
      end
      model_step(r_en, r_rd, r_tgt, r_rdy, r_rv, r_dat, r_ird);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the core.
- Issues one request at a time to instruction memory over a valid/ready request channel, then waits for a valid-only response.
- Presents the fetched word to decode over a valid/ready handshake.
- Handles sequential advance (PC+STEP), branch/jump redirects, flush of in-flight fetches, and start/stop.
- Sits between the pipeline's branch-resolution stage and instruction memory.

Parameters:
- XLEN, 32, width of PC and instruction word.
- RESET_PC, 32'h0, PC value loaded on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  fetch enable; 0 parks the sequencer in IDLE.
- redirect_valid  in  1  branch/jump taken this cycle; single-cycle pulse.
- redirect_target  in  XLEN  new PC when redirect_valid=1.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (= current pc).
- imem_rsp_valid  in  1  response data valid; memory returns exactly one response per accepted request.
- imem_rsp_data  in  XLEN  fetched instruction.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts instruction.
- if_pc  out  XLEN  PC of the presented instruction.
- if_instr  out  XLEN  presented instruction.
- fetch_count  out  32  number of instructions delivered (handshakes completed), wraps.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=IDLE, kill=0, imem_req_valid=0, if_valid=0, if_pc=0, if_instr=0, fetch_count=0. Reset mid-transaction abandons it; any later imem_rsp_valid while in IDLE is ignored.
- States: IDLE, REQ, WAIT, HOLD. imem_req_valid=1 only in REQ. if_valid=1 only in HOLD. imem_req_addr=pc, combinational from the register.
- IDLE:
  - en=1 -> REQ next cycle.
  - redirect_valid -> pc<=target.
- REQ:
  - redirect_valid=1 -> pc<=target, stay REQ. This rule has priority over acceptance; a request accepted in the same cycle sets kill=1 and goes to WAIT.
  - Otherwise, imem_req_ready=1 -> WAIT.
  - Otherwise, en=0 -> IDLE.
- WAIT:
  - On imem_rsp_valid with kill=0: if_instr<=rsp_data, if_pc<=pc -> HOLD.
  - On imem_rsp_valid with kill=1: discard data, kill<=0 -> REQ (or IDLE if en=0).
  - redirect_valid in WAIT: pc<=target, kill<=1. If it coincides with rsp_valid, the response is discarded, kill stays 0 -> REQ.
  - en=0 in WAIT does not abort; the response is still awaited.
- HOLD:
  - redirect_valid=1 has priority: the presented instruction is flushed, if_ready is ignored, fetch_count is not incremented, pc<=target -> REQ (IDLE if en=0).
  - Otherwise, if_ready=1: fetch_count++, pc<=pc+PC_STEP -> REQ (IDLE if en=0).
  - Otherwise, hold if_valid/if_pc/if_instr stable.
- Latency: first if_valid appears 3 cycles after en rises, given ready memory and a 1-cycle response. Steady-state throughput is 1 instruction per 3 cycles (no pipelining by design).
- Arithmetic: pc+PC_STEP is modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0). redirect_target[1:0] is forced to 0 on load.
- Invariant: at most one outstanding request; kill covers exactly that one.

Decomposition:
- Package fetch_pkg: state enum (IDLE/REQ/WAIT/HOLD), RESET_PC, PC_STEP, and the XLEN-wide pc type.
- One natural sub-module, pc_reg: holds pc with load-target/increment/hold controls, async reset to RESET_PC, alignment masking. The FSM and handshakes stay in fetch_sequencer.

Test Plan:
- Reset then en=1, memory always ready, 1-cycle rsp returning 0x13 -> req addrs 0x0, 0x4, 0x8; if_pc 0x0/0x4/0x8 each with if_instr=0x13; fetch_count=3 after 3 accepts.
- imem_req_ready held low 5 cycles -> imem_req_valid and addr=0x0 stable throughout; redirect to 0x100 during the stall -> addr changes to 0x100 next cycle, valid stays high.
- Redirect to 0x200 while in WAIT for 0x8 -> response for 0x8 discarded, next request addr=0x200, no if_valid for 0x8.
- if_ready low 4 cycles in HOLD -> if_pc/if_instr stable; redirect_valid and if_ready together -> no count increment, next addr = target.
- Redirect to 0xFFFF_FFFF -> pc loads 0xFFFF_FFFC; after accept, next addr=0x0 (wrap).
- Assert reset in WAIT, then deliver a stale rsp_valid -> all outputs at reset values, response ignored, fetch restarts at RESET_PC when en=1.
